// File: rtl/decode_issue.sv
// -----------------------------------------------------------------------------
// decode_issue
//   Decode/issue stage that sits directly in front of the register file.
//   One instruction per cycle is accepted into an instruction register (IR).
//   The IR drives the register-file read addresses, is checked against a
//   32-entry busy scoreboard of in-flight destinations, and is then issued
//   into a one-entry output register for the execute stage.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid/in_ready       upstream handshake; instr + pc_in are captured
//   read_address1/2         register-file read ports (rs / rt of the IR)
//   out_valid/out_ready     downstream handshake for the issued instruction
//   out_pc/opcode/funct     decoded fields of the issued instruction
//   out_write_address/_enable  destination register and its write flag
//   out_imm                 sign-extended instr[15:0]
//   wb_valid/wb_address     writeback retiring a destination (clears busy)
//   stall_count             saturating count of cycles spent stalled
// -----------------------------------------------------------------------------
module decode_issue #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned PC_W         = 16,
  parameter int unsigned NUM_READABLE = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] instr,
  input  logic [PC_W-1:0]   pc_in,
  output logic [ADDR_W-1:0] read_address1,
  output logic [ADDR_W-1:0] read_address2,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [5:0]        out_opcode,
  output logic [5:0]        out_funct,
  output logic [ADDR_W-1:0] out_write_address,
  output logic              out_write_enable,
  output logic [DATA_W-1:0] out_imm,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_address,
  output logic [15:0]       stall_count
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_W;

  // IR state encoding
  localparam logic [1:0] S_EMPTY  = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_STALL  = 2'd2;

  // Opcodes with special source/destination usage
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JUMP  = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_STORE = 6'h2b;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]          r_state;
  logic [DATA_W-1:0]   r_ir;
  logic [PC_W-1:0]     r_ir_pc;
  logic [NUM_REGS-1:0] r_busy;
  logic [15:0]         r_stall_cnt;

  logic                r_out_valid;
  logic [PC_W-1:0]     r_out_pc;
  logic [5:0]          r_out_opcode;
  logic [5:0]          r_out_funct;
  logic [ADDR_W-1:0]   r_out_wa;
  logic                r_out_we;
  logic [DATA_W-1:0]   r_out_imm;

  // ---------------------------------------------------------------------------
  // Decode of the IR
  // ---------------------------------------------------------------------------
  logic [5:0]          w_opcode;
  logic [ADDR_W-1:0]   w_rs;
  logic [ADDR_W-1:0]   w_rt;
  logic [ADDR_W-1:0]   w_rd;
  logic                w_use_rs;
  logic                w_use_rt;
  logic [ADDR_W-1:0]   w_dest;
  logic                w_we;
  logic [DATA_W-1:0]   w_imm;

  assign w_opcode = r_ir[31:26];
  assign w_rs     = r_ir[25:21];
  assign w_rt     = r_ir[20:16];
  assign w_rd     = r_ir[15:11];
  assign w_imm    = {{(DATA_W-16){r_ir[15]}}, r_ir[15:0]};

  always_comb begin
    w_use_rs = 1'b1;
    w_use_rt = 1'b0;
    w_dest   = '0;
    case (w_opcode)
      OP_RTYPE: begin
        w_use_rt = 1'b1;
        w_dest   = w_rd;
      end
      OP_STORE, OP_BEQ, OP_BNE: begin
        w_use_rt = 1'b1;
      end
      OP_JUMP: begin
        w_use_rs = 1'b0;
      end
      default: begin
        w_dest = w_rt;
      end
    endcase
  end

  // r0 is a hard zero: writing it is a no-op, so it never becomes busy.
  assign w_we = (w_dest != '0);

  // ---------------------------------------------------------------------------
  // Hazard detection against the registered busy vector (no bypass: a
  // writeback in this cycle only releases the stall on the next cycle).
  // Sources at or above NUM_READABLE read as zero and cannot hazard.
  // ---------------------------------------------------------------------------
  logic w_rs_readable;
  logic w_rt_readable;
  logic w_hazard;
  logic w_ir_valid;
  logic w_out_free;
  logic w_issue;
  logic w_load;

  assign w_rs_readable = (32'(w_rs) < NUM_READABLE);
  assign w_rt_readable = (32'(w_rt) < NUM_READABLE);

  assign w_hazard = (w_use_rs && w_rs_readable && r_busy[w_rs]) ||
                    (w_use_rt && w_rt_readable && r_busy[w_rt]) ||
                    (w_we && r_busy[w_dest]);

  assign w_ir_valid = (r_state != S_EMPTY);
  // Output register can take a new instruction if empty or draining now.
  assign w_out_free = !r_out_valid || out_ready;
  assign w_issue    = w_ir_valid && w_out_free && !w_hazard;

  // Accepting while issuing gives back-to-back throughput of one per cycle.
  assign in_ready = (r_state == S_EMPTY) || w_issue;
  assign w_load   = in_valid && in_ready;

  assign read_address1 = w_ir_valid ? w_rs : '0;
  assign read_address2 = w_ir_valid ? w_rt : '0;

  // ---------------------------------------------------------------------------
  // IR state machine
  // ---------------------------------------------------------------------------
  logic [1:0] w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_EMPTY || w_issue) begin
      w_state_nxt = w_load ? S_DECODE : S_EMPTY;
    end else begin
      // Holding an instruction that could not issue this cycle.
      w_state_nxt = S_STALL;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_EMPTY;
      r_ir    <= '0;
      r_ir_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_ir    <= instr;
        r_ir_pc <= pc_in;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (r_state == S_STALL && r_stall_cnt != 16'hFFFF) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Busy scoreboard. Clear from writeback is applied first so that a set of
  // the same register in the same cycle wins.
  // ---------------------------------------------------------------------------
  logic [NUM_REGS-1:0] w_busy_nxt;

  always_comb begin
    w_busy_nxt = r_busy;
    if (wb_valid) w_busy_nxt[wb_address] = 1'b0;
    if (w_issue && w_we) w_busy_nxt[w_dest] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_busy <= '0;
    else          r_busy <= w_busy_nxt;
  end

  // ---------------------------------------------------------------------------
  // Output register: fields are only written on issue so they stay stable
  // while out_valid waits for out_ready.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_pc     <= '0;
      r_out_opcode <= '0;
      r_out_funct  <= '0;
      r_out_wa     <= '0;
      r_out_we     <= 1'b0;
      r_out_imm    <= '0;
    end else if (w_issue) begin
      r_out_valid  <= 1'b1;
      r_out_pc     <= r_ir_pc;
      r_out_opcode <= w_opcode;
      r_out_funct  <= r_ir[5:0];
      r_out_wa     <= w_dest;
      r_out_we     <= w_we;
      r_out_imm    <= w_imm;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  assign out_valid         = r_out_valid;
  assign out_pc            = r_out_pc;
  assign out_opcode        = r_out_opcode;
  assign out_funct         = r_out_funct;
  assign out_write_address = r_out_wa;
  assign out_write_enable  = r_out_we;
  assign out_imm           = r_out_imm;
  assign stall_count       = r_stall_cnt;

endmodule

// File: tb/tb_decode_issue.sv
// Testbench for decode_issue: directed scenarios followed by random traffic.
// A reference model tracks register occupancy, busy registers and stall time
// from the decode rules; issued instructions are queued at acceptance and
// compared in order by an independent output monitor.
module tb_decode_issue;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [15:0] pc_in;
  logic [4:0]  read_address1;
  logic [4:0]  read_address2;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_pc;
  logic [5:0]  out_opcode;
  logic [5:0]  out_funct;
  logic [4:0]  out_write_address;
  logic        out_write_enable;
  logic [31:0] out_imm;
  logic        wb_valid;
  logic [4:0]  wb_address;
  logic [15:0] stall_count;

  decode_issue dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc_in(pc_in),
    .read_address1(read_address1), .read_address2(read_address2),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct(out_funct),
    .out_write_address(out_write_address), .out_write_enable(out_write_enable),
    .out_imm(out_imm), .wb_valid(wb_valid), .wb_address(wb_address),
    .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] pc;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  wa;
    logic        we;
    logic [31:0] imm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  bit          m_irv;
  logic [31:0] m_ir;
  int          m_age;
  bit          m_ov;
  bit          m_busy[32];
  int          m_stall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Which registers an instruction reads and writes (dest 0 = none).
  function automatic void classify(input logic [31:0] ins, output bit urs,
                                   output bit urt, output int dst);
    int op;
    op = int'(ins[31:26]);
    if (op == 0) begin
      urs = 1; urt = 1; dst = int'(ins[15:11]);
    end else if (op == 'h2b || op == 'h04 || op == 'h05) begin
      urs = 1; urt = 1; dst = 0;
    end else if (op == 'h02) begin
      urs = 0; urt = 0; dst = 0;
    end else begin
      urs = 1; urt = 0; dst = int'(ins[20:16]);
    end
  endfunction

  function automatic exp_t expect_of(input logic [31:0] ins, input logic [15:0] pc);
    exp_t e;
    bit urs, urt;
    int dst, imm;
    classify(ins, urs, urt, dst);
    imm = int'(ins[15:0]);
    if (imm >= 32768) imm = imm - 65536;
    e.pc  = pc;
    e.op  = ins[31:26];
    e.fn  = ins[5:0];
    e.wa  = 5'(dst);
    e.we  = (dst != 0);
    e.imm = 32'(imm);
    return e;
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
  endfunction

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  // One clock cycle: drive inputs, check control outputs against the model,
  // then advance the model across the rising edge.
  task automatic cyc(input bit iv, input logic [31:0] ins, input logic [15:0] pc,
                     input bit ordy, input bit wv, input logic [4:0] wa);
    bit urs, urt, blk, iss, exp_ir;
    int dst, rs, rt;
    @(negedge clk);
    in_valid = iv; instr = ins; pc_in = pc; out_ready = ordy;
    wb_valid = wv; wb_address = wa;
    #1;
    classify(m_ir, urs, urt, dst);
    rs  = int'(m_ir[25:21]);
    rt  = int'(m_ir[20:16]);
    blk = (urs && rs < 24 && m_busy[rs]) || (urt && rt < 24 && m_busy[rt]) ||
          (dst != 0 && m_busy[dst]);
    iss = m_irv && (!m_ov || ordy) && !blk;
    exp_ir = !m_irv || iss;
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    chk("out_valid", 32'(out_valid), 32'(m_ov));
    chk("stall_count", 32'(stall_count), 32'(m_stall));
    chk("read_address1", 32'(read_address1), m_irv ? 32'(rs) : 32'd0);
    chk("read_address2", 32'(read_address2), m_irv ? 32'(rt) : 32'd0);
    @(posedge clk);
    if (m_ov && ordy) m_ov = 0;
    if (wv && wa != 0) m_busy[int'(wa)] = 0;
    if (iss) begin
      m_ov = 1;
      if (dst != 0) m_busy[dst] = 1;
    end
    if (m_irv && m_age > 0 && m_stall < 65535) m_stall++;
    if (exp_ir) begin
      if (iv) begin
        m_irv = 1; m_ir = ins; m_age = 0;
        q.push_back(expect_of(ins, pc));
      end else begin
        m_irv = 0;
      end
    end else begin
      m_age++;
    end
  endtask

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cyc(0, 32'd0, 16'd0, ordy, 0, 5'd0);
  endtask

  task automatic wb(input int r);
    cyc(0, 32'd0, 16'd0, 1, 1, 5'(r));
  endtask

  task automatic model_reset();
    m_irv = 0; m_ir = '0; m_age = 0; m_ov = 0; m_stall = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    q.delete();
  endtask

  // Asynchronous reset in the middle of a cycle, away from any edge.
  task automatic async_reset();
    @(negedge clk);
    in_valid = 0; out_ready = 1; wb_valid = 0;
    #2;
    reset_n = 0;
    model_reset();
    #1;
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst stall_count", 32'(stall_count), 32'd0);
    chk("rst out_fields", {out_pc, out_opcode, out_funct, out_write_address, out_write_enable},
        32'd0);
    chk("rst out_imm", out_imm, 32'd0);
    chk("rst read_addr", {22'd0, read_address1, read_address2}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1;
  endtask

  // Output monitor: compares the presented instruction with the oldest
  // expected one every cycle it is valid; pops on handshake.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: pc %0h issued with nothing expected", out_pc);
        end else begin
          if ({out_pc, out_opcode, out_funct, out_write_address, out_write_enable, out_imm}
              !== q[0]) begin
            errors++;
            $display("FAIL out_fields: got pc %0h op %0h fn %0h wa %0d we %0b imm %0h expected pc %0h op %0h fn %0h wa %0d we %0b imm %0h",
                     out_pc, out_opcode, out_funct, out_write_address, out_write_enable, out_imm,
                     q[0].pc, q[0].op, q[0].fn, q[0].wa, q[0].we, q[0].imm);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] ins;
    int op, r;
    reset_n = 0; in_valid = 0; instr = '0; pc_in = '0; out_ready = 0;
    wb_valid = 0; wb_address = '0;
    model_reset();
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset stall_count", 32'(stall_count), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1;

    // Independent back-to-back stream
    cyc(1, enc_r(1, 2, 3, 'h20), 16'h0000, 1, 0, 0);
    cyc(1, enc_i('h08, 4, 5, 'h10), 16'h0004, 1, 0, 0);
    idle(2, 1);
    wb(3); wb(5);

    // RAW stall released by writeback
    cyc(1, enc_r(1, 2, 3, 'h20), 16'h0008, 1, 0, 0);
    cyc(1, enc_r(3, 1, 6, 'h22), 16'h000c, 1, 0, 0);
    idle(2, 1);
    wb(3);
    idle(3, 1);
    wb(6);

    // Backpressure: output held, IR held, then drain and issue together
    cyc(1, enc_i('h08, 0, 8, 1), 16'h0010, 0, 0, 0);
    cyc(1, enc_i('h08, 0, 9, 2), 16'h0014, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, enc_i('h08, 0, 10, 3), 16'h0018, 0, 0, 0);
    idle(3, 1);
    wb(8); wb(9);

    // Boundaries: dest r0, unreadable source, negative imm, store/branch/jump
    cyc(1, enc_r(1, 2, 0, 'h20), 16'h0020, 1, 0, 0);
    cyc(1, enc_i('h08, 0, 25, 5), 16'h0024, 1, 0, 0);
    cyc(1, enc_r(25, 26, 10, 'h25), 16'h0028, 1, 0, 0);
    cyc(1, enc_i('h08, 0, 11, 'h8000), 16'h002c, 1, 0, 0);
    cyc(1, enc_i('h2b, 1, 2, 'h7fff), 16'h0030, 1, 0, 0);
    cyc(1, enc_i('h04, 1, 2, 'hfffe), 16'h0034, 1, 0, 0);
    cyc(1, {6'h02, 26'h3ffffff}, 16'h0038, 1, 0, 0);
    idle(2, 1);
    wb(25); wb(10); wb(11);

    // Same-cycle set/clear of r7: set wins, a later reader stalls
    cyc(1, enc_i('h08, 0, 7, 1), 16'h0040, 1, 0, 0);
    cyc(0, 32'd0, 16'd0, 1, 1, 5'd7);
    cyc(1, enc_r(7, 0, 12, 'h20), 16'h0044, 1, 0, 0);
    idle(3, 1);
    wb(7);
    idle(2, 1);
    wb(12);

    // wb to r0 is harmless
    cyc(1, enc_i('h08, 0, 13, 4), 16'h0048, 1, 1, 5'd0);
    cyc(1, enc_r(13, 0, 14, 'h20), 16'h004c, 1, 1, 5'd0);
    idle(3, 1);

    // Reset while stalled with busy bits set, then a clean reader
    async_reset();
    cyc(1, enc_r(13, 0, 14, 'h20), 16'h0050, 1, 0, 0);
    idle(2, 1);
    wb(14);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      op = $urandom_range(0, 7);
      case (op)
        0: op = 'h00;
        1: op = 'h2b;
        2: op = 'h04;
        3: op = 'h02;
        4: op = 'h23;
        5: op = 'h08;
        default: op = int'($urandom_range(0, 63));
      endcase
      ins = $urandom;
      ins[31:26] = 6'(op);
      for (int f = 0; f < 3; f++)
        if ($urandom_range(0, 9) < 6) ins[25 - 5*f -: 5] = 5'($urandom_range(0, 7));
      r = 0;
      if ($urandom_range(0, 9) < 4) begin
        for (int t = 0; t < 8; t++) begin
          r = int'($urandom_range(0, 31));
          if (m_busy[r]) break;
        end
      end
      cyc($urandom_range(0, 9) < 7, ins, 16'($urandom), $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) < 4, 5'(r));
    end

    // Drain everything
    for (int i = 1; i < 32; i++) wb(i);
    idle(4, 1);
    chk("drain queue empty", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
